// File: rtl/cmd_pkg.sv
// Shared types and codes for the command-frame controller and its executors.
package cmd_pkg;

  // Controller states; the numeric encoding is exported on the debug port.
  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_IDLE   = 3'd1,
    S_ARGS   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_RESP   = 3'd5,
    S_GUARD  = 3'd6,
    S_TXWT   = 3'd7
  } state_t;

  // Verb codes. PING is answered locally; the others go to an executor.
  localparam logic [7:0] V_PING = 8'd2;
  localparam logic [7:0] V_DISP = 8'd3;
  localparam logic [7:0] V_LEDS = 8'd4;
  localparam logic [7:0] V_MTNE = 8'd5;

  // Highest verb accepted by the decoder.
  localparam logic [7:0] MAX_VERB = 8'd15;

  // Bytes sent back to the host.
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] BOOT_BYTE = 8'h52;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte timeout counter: counts enabled cycles, saturates at its
// terminal count and flags expiry on any enabled cycle spent there.
// A clear in the same cycle takes priority and suppresses the flag.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up to the terminal value and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TERM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/cmd_frame_fsm.sv
// Command-frame controller: collects a verb plus NUM_ARGS argument bytes,
// answers PING locally, dispatches other legal verbs to an executor and
// sends exactly one response byte per completed frame (plus a boot byte).
//
// Handshakes: rx_valid and cmd_done are single-cycle strobes sampled on the
// rising clock edge; tx_start and cmd_valid are registered single-cycle
// pulses. tx_data is registered and holds until the next transmit request.
module cmd_frame_fsm #(
  parameter int                DATA_W      = 8,
  parameter int                NUM_ARGS    = 3,
  parameter int                TIMEOUT_CYC = 500000,
  parameter logic [DATA_W-1:0] MAX_VERB    = cmd_pkg::MAX_VERB,
  parameter logic [DATA_W-1:0] V_PING      = cmd_pkg::V_PING,
  parameter logic [DATA_W-1:0] BOOT_BYTE   = cmd_pkg::BOOT_BYTE,
  parameter logic [DATA_W-1:0] RSP_OK      = cmd_pkg::RSP_OK,
  parameter logic [DATA_W-1:0] RSP_ERR     = cmd_pkg::RSP_ERR
) (
  input  logic                                          clk50m,
  input  logic                                          reset,
  input  logic [DATA_W-1:0]                             rx_data,
  input  logic                                          rx_valid,
  input  logic                                          tx_busy,
  output logic [DATA_W-1:0]                             tx_data,
  output logic                                          tx_start,
  output logic                                          cmd_valid,
  output logic [DATA_W-1:0]                             cmd_verb,
  output logic [((NUM_ARGS > 0) ? NUM_ARGS : 1)*DATA_W-1:0] cmd_args,
  input  logic                                          cmd_done,
  input  logic                                          cmd_err,
  output logic                                          frame_err,
  output logic                                          rx_overrun,
  output logic [2:0]                                    state
);

  import cmd_pkg::*;

  localparam int ARGS_W = ((NUM_ARGS > 0) ? NUM_ARGS : 1) * DATA_W;
  localparam int IDX_W  = (NUM_ARGS > 0) ? $clog2(NUM_ARGS + 1) : 1;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   verb_q, verb_d;
  logic [ARGS_W-1:0]   args_q, args_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                rx_overrun_q, rx_overrun_d;

  logic tmr_clr, tmr_en, tmr_expired;

  // The timer runs only while collecting arguments; any accepted byte restarts it.
  assign tmr_en  = (state_q == S_ARGS);
  assign tmr_clr = rx_valid && ((state_q == S_IDLE) || (state_q == S_ARGS));

  byte_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk50m),
    .rst_n   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Next-state and registered-output logic for the frame controller.
  always_comb begin
    state_d      = state_q;
    verb_d       = verb_q;
    args_d       = args_q;
    idx_d        = idx_q;
    rsp_d        = rsp_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    cmd_valid_d  = 1'b0;
    frame_err_d  = 1'b0;
    // Bytes are only accepted while a frame can still absorb them.
    rx_overrun_d = rx_valid && (state_q != S_IDLE) && (state_q != S_ARGS);

    case (state_q)
      S_BOOT: begin
        if (!tx_busy) begin
          tx_data_d  = BOOT_BYTE;
          tx_start_d = 1'b1;
          state_d    = S_GUARD;
        end
      end
      S_IDLE: begin
        if (rx_valid) begin
          verb_d  = rx_data;
          idx_d   = '0;
          state_d = (NUM_ARGS == 0) ? S_DECODE : S_ARGS;
        end
      end
      S_ARGS: begin
        if (rx_valid) begin
          for (int i = 0; i < NUM_ARGS; i++) begin
            if (int'(idx_q) == i) begin
              args_d[i*DATA_W +: DATA_W] = rx_data;
            end
          end
          idx_d = idx_q + 1'b1;
          if (int'(idx_q) == NUM_ARGS - 1) begin
            state_d = S_DECODE;
          end
        end else if (tmr_expired) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DECODE: begin
        if ((verb_q == '0) || (verb_q > MAX_VERB)) begin
          rsp_d   = RSP_ERR;
          state_d = S_RESP;
        end else if (verb_q == V_PING) begin
          rsp_d   = V_PING;
          state_d = S_RESP;
        end else begin
          cmd_valid_d = 1'b1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cmd_done) begin
          rsp_d   = cmd_err ? RSP_ERR : RSP_OK;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (!tx_busy) begin
          tx_data_d  = rsp_q;
          tx_start_d = 1'b1;
          state_d    = S_GUARD;
        end
      end
      // The transmitter raises tx_busy one cycle after tx_start, so skip a cycle.
      S_GUARD: state_d = S_TXWT;
      S_TXWT: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State and output registers; reset aborts any frame or transmit in flight.
  always_ff @(posedge clk50m or negedge reset) begin
    if (!reset) begin
      state_q      <= S_BOOT;
      verb_q       <= '0;
      args_q       <= '0;
      idx_q        <= '0;
      rsp_q        <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      cmd_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      verb_q       <= verb_d;
      args_q       <= args_d;
      idx_q        <= idx_d;
      rsp_q        <= rsp_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      cmd_valid_q  <= cmd_valid_d;
      frame_err_q  <= frame_err_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign state      = state_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_verb   = verb_q;
  assign cmd_args   = args_q;
  assign frame_err  = frame_err_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_cmd_frame_fsm.sv
// Directed bench for cmd_frame_fsm: boot byte, PING, dispatched commands,
// illegal verbs, inter-byte timeout (and its boundary), overrun and reset abort.
module tb_cmd_frame_fsm;

  localparam int TC = 20;

  localparam logic [2:0] ST_BOOT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_ARGS  = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;
  localparam logic [2:0] ST_GUARD = 3'd6;
  localparam logic [2:0] ST_TXWT  = 3'd7;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        cmd_valid;
  logic [7:0]  cmd_verb;
  logic [23:0] cmd_args;
  logic        cmd_done;
  logic        cmd_err;
  logic        frame_err;
  logic        rx_overrun;
  logic [2:0]  state;

  int vectors     = 0;
  int miscompares = 0;
  int n_tx = 0, n_cv = 0, n_fe = 0, n_ov = 0;
  int tx0, fe0, ov0;

  cmd_frame_fsm #(
    .DATA_W      (8),
    .NUM_ARGS    (3),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk50m     (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_busy    (tx_busy),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .cmd_valid  (cmd_valid),
    .cmd_verb   (cmd_verb),
    .cmd_args   (cmd_args),
    .cmd_done   (cmd_done),
    .cmd_err    (cmd_err),
    .frame_err  (frame_err),
    .rx_overrun (rx_overrun),
    .state      (state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_start)   n_tx++;
    if (cmd_valid)  n_cv++;
    if (frame_err)  n_fe++;
    if (rx_overrun) n_ov++;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed no end expected end");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic [7:0] a0,
                            input logic [7:0] a1, input logic [7:0] a2);
    send_byte(v);
    send_byte(a0);
    send_byte(a1);
    send_byte(a2);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((state !== ST_IDLE) && (k < 50)) begin
      tick();
      k++;
    end
    check(tag, state, ST_IDLE);
  endtask

  logic [7:0] bad_v [2];

  initial begin
    reset = 1'b0; rx_data = '0; rx_valid = 1'b0; tx_busy = 1'b0;
    cmd_done = 1'b0; cmd_err = 1'b0;
    bad_v[0] = 8'h00;
    bad_v[1] = 8'h20;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_state", state, ST_BOOT);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_verb", cmd_verb, 0);
    check("rst_cmd_args", cmd_args, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_overrun", rx_overrun, 0);

    // Boot byte on the first cycle after release
    reset = 1'b1;
    tick();
    check("boot_tx_start", tx_start, 1);
    check("boot_tx_data", tx_data, 8'h52);
    check("boot_state", state, ST_GUARD);
    tick();
    check("boot_tx_pulse", tx_start, 0);
    wait_idle("boot_idle");
    repeat (10) tick();
    check("boot_tx_count", n_tx, 1);

    // PING echoes the verb, 3 cycles after the last byte
    send_frame(8'h02, 8'h11, 8'h22, 8'h33);
    tick();
    check("ping_early", tx_start, 0);
    tick();
    check("ping_tx_start", tx_start, 1);
    check("ping_tx_data", tx_data, 8'h02);
    wait_idle("ping_idle");
    check("ping_no_dispatch", n_cv, 0);

    // Dispatched verb, executor success
    send_frame(8'h05, 8'hAA, 8'hBB, 8'hCC);
    tick();
    check("ok_cmd_valid", cmd_valid, 1);
    check("ok_cmd_verb", cmd_verb, 8'h05);
    check("ok_cmd_args", cmd_args, 24'hCCBBAA);
    check("ok_state_exec", state, ST_EXEC);
    repeat (9) tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    check("ok_state_resp", state, ST_RESP);
    tick();
    check("ok_tx_start", tx_start, 1);
    check("ok_tx_data", tx_data, 8'h4B);
    wait_idle("ok_idle");
    check("ok_cv_count", n_cv, 1);

    // Dispatched verb, executor error; overrun in EXEC; tx_busy back-pressure
    send_frame(8'h05, 8'hAA, 8'hBB, 8'hCC);
    tick();
    check("err_cmd_valid", cmd_valid, 1);
    tick();
    ov0 = n_ov;
    send_byte(8'h77);
    check("ovr_pulse", rx_overrun, 1);
    check("ovr_args_kept", cmd_args, 24'hCCBBAA);
    check("ovr_state", state, ST_EXEC);
    tx_busy  = 1'b1;
    cmd_done = 1'b1;
    cmd_err  = 1'b1;
    tick();
    cmd_done = 1'b0;
    cmd_err  = 1'b0;
    repeat (3) tick();
    check("busy_no_start", tx_start, 0);
    check("busy_state_resp", state, ST_RESP);
    check("ovr_count", n_ov, ov0 + 1);
    tx_busy = 1'b0;
    tick();
    check("err_tx_start", tx_start, 1);
    check("err_tx_data", tx_data, 8'h45);
    tx_busy = 1'b1;
    tick();
    repeat (3) tick();
    check("txwt_hold_state", state, ST_TXWT);
    check("txwt_hold_data", tx_data, 8'h45);
    tx_busy = 1'b0;
    tick();
    check("txwt_exit", state, ST_IDLE);
    check("err_cv_count", n_cv, 2);

    // Illegal verbs: zero and above MAX_VERB
    for (int i = 0; i < 2; i++) begin
      send_frame(bad_v[i], 8'h01, 8'h02, 8'h03);
      tick();
      tick();
      check("bad_tx_start", tx_start, 1);
      check("bad_tx_data", tx_data, 8'h45);
      wait_idle("bad_idle");
    end
    check("bad_no_dispatch", n_cv, 2);

    // Inter-byte timeout
    fe0 = n_fe;
    tx0 = n_tx;
    send_byte(8'h05);
    send_byte(8'hAA);
    repeat (TC - 1) tick();
    check("to_not_yet", frame_err, 0);
    check("to_still_args", state, ST_ARGS);
    tick();
    check("to_frame_err", frame_err, 1);
    check("to_state_idle", state, ST_IDLE);
    repeat (5) tick();
    check("to_fe_count", n_fe, fe0 + 1);
    check("to_no_tx", n_tx, tx0);
    send_frame(8'h02, 8'h11, 8'h22, 8'h33);
    tick();
    tick();
    check("to_new_verb_tx", tx_start, 1);
    check("to_new_verb_data", tx_data, 8'h02);
    wait_idle("to_new_idle");

    // Byte on the terminal timer cycle wins over the timeout
    send_byte(8'h06);
    send_byte(8'h11);
    repeat (TC - 1) tick();
    send_byte(8'h22);
    check("edge_no_fe", frame_err, 0);
    check("edge_state", state, ST_ARGS);
    send_byte(8'h33);
    tick();
    check("edge_cmd_valid", cmd_valid, 1);
    check("edge_cmd_verb", cmd_verb, 8'h06);
    check("edge_cmd_args", cmd_args, 24'h332211);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
    check("edge_tx_data", tx_data, 8'h4B);
    check("edge_tx_start", tx_start, 1);
    wait_idle("edge_idle");
    check("edge_fe_count", n_fe, fe0 + 1);

    // Reset in the middle of a frame
    send_byte(8'h05);
    send_byte(8'h99);
    check("mid_state_args", state, ST_ARGS);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_state", state, ST_BOOT);
    check("mid_rst_verb", cmd_verb, 0);
    check("mid_rst_args", cmd_args, 0);
    check("mid_rst_tx_start", tx_start, 0);
    tx0 = n_tx;
    tick();
    reset = 1'b1;
    tick();
    check("reboot_tx_start", tx_start, 1);
    check("reboot_tx_data", tx_data, 8'h52);
    wait_idle("reboot_idle");
    repeat (5) tick();
    check("reboot_tx_count", n_tx, tx0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
